// File: rtl/lc3_pkg.sv
// Shared LC3 opcode encodings, writeback-source select and register count.
package lc3_pkg;

   localparam int unsigned NREG = 8;

   localparam logic [3:0] OP_BR   = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_LD   = 4'd2;
   localparam logic [3:0] OP_ST   = 4'd3;
   localparam logic [3:0] OP_JSR  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_LDR  = 4'd6;
   localparam logic [3:0] OP_STR  = 4'd7;
   localparam logic [3:0] OP_RTI  = 4'd8;
   localparam logic [3:0] OP_NOT  = 4'd9;
   localparam logic [3:0] OP_LDI  = 4'd10;
   localparam logic [3:0] OP_STI  = 4'd11;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_RES  = 4'd13;
   localparam logic [3:0] OP_LEA  = 4'd14;
   localparam logic [3:0] OP_TRAP = 4'd15;

   // Writeback data source select consumed by the writeback stage.
   typedef enum logic [1:0] {
      W_ALU = 2'd0,
      W_MEM = 2'd1,
      W_PC  = 2'd2
   } w_ctrl_e;

endpackage

// File: rtl/lc3_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
module lc3_scoreboard
   import lc3_pkg::*;
#(
   parameter int unsigned NREG      = lc3_pkg::NREG,
   parameter bit          WB_BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [2:0]      wb_dr,
   input  logic            set_en,
   input  logic [2:0]      set_dr,
   output logic [NREG-1:0] busy,
   output logic [NREG-1:0] sb_eff
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] clr;
   logic [NREG-1:0] set;
   logic [NREG-1:0] one;

   assign one = {{(NREG-1){1'b0}}, 1'b1};

   // Decode the retiring and newly-issued destinations into one-hot masks.
   always_comb begin
      clr = '0;
      set = '0;
      if (wb_valid) clr = one << wb_dr;
      if (set_en)   set = one << set_dr;
   end

   // Set is applied after clear so a freshly issued write to the retiring
   // register stays pending.
   always_comb begin
      busy_d = (busy_q & ~clr) | set;
   end

   // Hazard view: with bypass, a same-cycle retire already frees the register.
   always_comb begin
      if (WB_BYPASS) sb_eff = busy_q & ~clr;
      else           sb_eff = busy_q;
   end

   // Busy register; reset discards every pending write.
   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/decode_issue.sv
// LC3 decode/issue stage: decodes register fields, stalls on scoreboard
// hazards and holds one registered output slot behind a valid/ready handshake.
module decode_issue
   import lc3_pkg::*;
#(
   parameter int unsigned NREG      = lc3_pkg::NREG,
   parameter bit          WB_BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     in_ir,
   input  logic [15:0]     in_npc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [15:0]     out_ir,
   output logic [15:0]     out_npc,
   output logic [2:0]      out_sr1,
   output logic [2:0]      out_sr2,
   output logic [2:0]      out_dr,
   output logic [1:0]      out_W_Control,
   output logic            out_wb_en,
   output logic            out_illegal,
   input  logic            wb_valid,
   input  logic [2:0]      wb_dr,
   output logic [NREG-1:0] busy_mask
);

   logic [3:0]      op;
   logic [2:0]      dec_sr1;
   logic [2:0]      dec_sr2;
   logic [2:0]      dec_dr;
   logic            sr1_used;
   logic            sr2_used;
   logic            dec_wb_en;
   logic            dec_illegal;
   logic            is_br;
   w_ctrl_e         dec_w;
   logic [NREG-1:0] sb_eff;
   logic            hazard;
   logic            accept;

   assign op = in_ir[15:12];

   // Field decode; unused index fields are forced to zero.
   always_comb begin
      dec_sr1     = 3'd0;
      dec_sr2     = 3'd0;
      dec_dr      = 3'd0;
      sr1_used    = 1'b0;
      sr2_used    = 1'b0;
      dec_wb_en   = 1'b0;
      dec_illegal = 1'b0;
      is_br       = 1'b0;
      dec_w       = W_ALU;
      case (op)
         OP_ADD, OP_AND: begin
            dec_dr    = in_ir[11:9];
            dec_sr1   = in_ir[8:6];
            sr1_used  = 1'b1;
            dec_wb_en = 1'b1;
            if (!in_ir[5]) begin
               dec_sr2  = in_ir[2:0];
               sr2_used = 1'b1;
            end
         end
         OP_NOT: begin
            dec_dr    = in_ir[11:9];
            dec_sr1   = in_ir[8:6];
            sr1_used  = 1'b1;
            dec_wb_en = 1'b1;
         end
         OP_LD, OP_LDI: begin
            dec_dr    = in_ir[11:9];
            dec_wb_en = 1'b1;
            dec_w     = W_MEM;
         end
         OP_LDR: begin
            dec_dr    = in_ir[11:9];
            dec_sr1   = in_ir[8:6];
            sr1_used  = 1'b1;
            dec_wb_en = 1'b1;
            dec_w     = W_MEM;
         end
         OP_LEA: begin
            dec_dr    = in_ir[11:9];
            dec_wb_en = 1'b1;
            dec_w     = W_PC;
         end
         OP_ST, OP_STI: begin
            dec_sr2  = in_ir[11:9];
            sr2_used = 1'b1;
         end
         OP_STR: begin
            dec_sr1  = in_ir[8:6];
            dec_sr2  = in_ir[11:9];
            sr1_used = 1'b1;
            sr2_used = 1'b1;
         end
         OP_JMP: begin
            dec_sr1  = in_ir[8:6];
            sr1_used = 1'b1;
         end
         OP_BR: begin
            is_br = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   lc3_scoreboard #(
      .NREG      (NREG),
      .WB_BYPASS (WB_BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .wb_dr    (wb_dr),
      .set_en   (accept && dec_wb_en),
      .set_dr   (dec_dr),
      .busy     (busy_mask),
      .sb_eff   (sb_eff)
   );

   // RAW on used sources, WAW on the destination, and BR waits for any
   // pending write because every write also updates the condition codes.
   always_comb begin
      hazard = 1'b0;
      if (in_valid) begin
         if (sr1_used && sb_eff[dec_sr1]) hazard = 1'b1;
         if (sr2_used && sb_eff[dec_sr2]) hazard = 1'b1;
         if (dec_wb_en && sb_eff[dec_dr]) hazard = 1'b1;
         if (is_br && (|sb_eff))          hazard = 1'b1;
      end
   end

   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // Output slot: load on accept, drain when consumed, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_ir        <= 16'd0;
         out_npc       <= 16'd0;
         out_sr1       <= 3'd0;
         out_sr2       <= 3'd0;
         out_dr        <= 3'd0;
         out_W_Control <= 2'd0;
         out_wb_en     <= 1'b0;
         out_illegal   <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_ir        <= in_ir;
         out_npc       <= in_npc;
         out_sr1       <= dec_sr1;
         out_sr2       <= dec_sr2;
         out_dr        <= dec_dr;
         out_W_Control <= dec_w;
         out_wb_en     <= dec_wb_en;
         out_illegal   <= dec_illegal;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: inputs change on the falling edge and
// outputs are checked just after it, well clear of the rising edge.
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_ir;
   logic [15:0] in_npc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_ir;
   logic [15:0] out_npc;
   logic [2:0]  out_sr1;
   logic [2:0]  out_sr2;
   logic [2:0]  out_dr;
   logic [1:0]  out_W_Control;
   logic        out_wb_en;
   logic        out_illegal;
   logic        wb_valid;
   logic [2:0]  wb_dr;
   logic [7:0]  busy_mask;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decode_issue #(
      .NREG      (8),
      .WB_BYPASS (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_ir         (in_ir),
      .in_npc        (in_npc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_ir        (out_ir),
      .out_npc       (out_npc),
      .out_sr1       (out_sr1),
      .out_sr2       (out_sr2),
      .out_dr        (out_dr),
      .out_W_Control (out_W_Control),
      .out_wb_en     (out_wb_en),
      .out_illegal   (out_illegal),
      .wb_valid      (wb_valid),
      .wb_dr         (wb_dr),
      .busy_mask     (busy_mask)
   );

   // Advance one rising edge and settle just after the next falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_ir = 16'h0; in_npc = 16'h0;
      out_ready = 1'b0; wb_valid = 1'b0; wb_dr = 3'd0;
      cyc(); cyc();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (busy_mask !== 8'h00) begin n_bad++; $display("FAIL reset_busy got %h want 00", busy_mask); end
      n_cmp++; if ({out_ir, out_npc, out_sr1, out_sr2, out_dr, out_W_Control, out_wb_en, out_illegal} !== 45'd0) begin
         n_bad++; $display("FAIL reset_fields got ir=%h npc=%h dr=%0d wb_en=%b want all 0", out_ir, out_npc, out_dr, out_wb_en);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_ir = 16'h1283; in_npc = 16'h3001; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready got %b want 1", in_ready); end
      cyc();
      in_valid = 1'b0; #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_out_valid got %b want 1", out_valid); end
      n_cmp++; if ({out_dr, out_sr1, out_sr2} !== {3'd1, 3'd2, 3'd3}) begin
         n_bad++; $display("FAIL add_regs got dr=%0d sr1=%0d sr2=%0d want 1 2 3", out_dr, out_sr1, out_sr2);
      end
      n_cmp++; if ({out_W_Control, out_wb_en, out_illegal} !== {2'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL add_ctrl got W=%0d wb_en=%b ill=%b want 0 1 0", out_W_Control, out_wb_en, out_illegal);
      end
      n_cmp++; if (out_npc !== 16'h3001) begin n_bad++; $display("FAIL add_npc got %h want 3001", out_npc); end
      n_cmp++; if (busy_mask !== 8'h02) begin n_bad++; $display("FAIL add_busy got %h want 02", busy_mask); end
   endtask

   task automatic test_raw_bypass();
      out_ready = 1'b1; in_valid = 1'b1; in_ir = 16'h6840; in_npc = 16'h3002; #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall got %b want 0", in_ready); end
      cyc();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL raw_drain got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall2 got %b want 0", in_ready); end
      wb_valid = 1'b1; wb_dr = 3'd1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass got %b want 1", in_ready); end
      cyc();
      wb_valid = 1'b0; in_valid = 1'b0; #1;
      n_cmp++; if (busy_mask !== 8'h10) begin n_bad++; $display("FAIL ldr_busy got %h want 10", busy_mask); end
      n_cmp++; if ({out_dr, out_sr1, out_sr2, out_W_Control} !== {3'd4, 3'd1, 3'd0, 2'd1}) begin
         n_bad++; $display("FAIL ldr_fields got dr=%0d sr1=%0d sr2=%0d W=%0d want 4 1 0 1", out_dr, out_sr1, out_sr2, out_W_Control);
      end
   endtask

   task automatic test_br_cc();
      in_valid = 1'b1; in_ir = 16'h0402; in_npc = 16'h3003; #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL br_stall got %b want 0", in_ready); end
      cyc();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL br_stall2 got %b want 0", in_ready); end
      wb_valid = 1'b1; wb_dr = 3'd4; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL br_release got %b want 1", in_ready); end
      cyc();
      wb_valid = 1'b0; in_valid = 1'b0; #1;
      n_cmp++; if (out_ir !== 16'h0402) begin n_bad++; $display("FAIL br_ir got %h want 0402", out_ir); end
      n_cmp++; if ({out_sr1, out_sr2, out_dr, out_wb_en} !== 10'd0) begin
         n_bad++; $display("FAIL br_fields got sr1=%0d sr2=%0d dr=%0d wb_en=%b want 0", out_sr1, out_sr2, out_dr, out_wb_en);
      end
      n_cmp++; if (busy_mask !== 8'h00) begin n_bad++; $display("FAIL br_busy got %h want 00", busy_mask); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; in_ir = 16'h1283; in_npc = 16'h3004;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
         n_cmp++; if ({out_valid, out_ir, out_npc} !== {1'b1, 16'h0402, 16'h3003}) begin
            n_bad++; $display("FAIL bp_hold[%0d] got v=%b ir=%h npc=%h want 1 0402 3003", i, out_valid, out_ir, out_npc);
         end
         cyc();
      end
      out_ready = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b want 1", in_ready); end
      cyc();
      in_valid = 1'b0; #1;
      n_cmp++; if ({out_valid, out_ir} !== {1'b1, 16'h1283}) begin
         n_bad++; $display("FAIL bp_next got v=%b ir=%h want 1 1283", out_valid, out_ir);
      end
      n_cmp++; if (busy_mask !== 8'h02) begin n_bad++; $display("FAIL bp_busy got %h want 02", busy_mask); end
   endtask

   task automatic test_wb_collision();
      in_valid = 1'b1; in_ir = 16'hEA01; in_npc = 16'h3005;
      cyc();
      n_cmp++; if (busy_mask !== 8'h22) begin n_bad++; $display("FAIL lea1_busy got %h want 22", busy_mask); end
      // Second LEA R5 collides with the retire of R5 in the same cycle.
      wb_valid = 1'b1; wb_dr = 3'd5; in_npc = 16'h3006; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lea_waw_bypass got %b want 1", in_ready); end
      cyc();
      wb_valid = 1'b0; in_valid = 1'b0; #1;
      n_cmp++; if (busy_mask !== 8'h22) begin n_bad++; $display("FAIL lea_set_wins got %h want 22", busy_mask); end
      n_cmp++; if ({out_W_Control, out_dr, out_npc} !== {2'd2, 3'd5, 16'h3006}) begin
         n_bad++; $display("FAIL lea_fields got W=%0d dr=%0d npc=%h want 2 5 3006", out_W_Control, out_dr, out_npc);
      end
      // Retire of an idle register leaves the scoreboard untouched.
      wb_valid = 1'b1; wb_dr = 3'd7;
      cyc();
      wb_valid = 1'b0; #1;
      n_cmp++; if (busy_mask !== 8'h22) begin n_bad++; $display("FAIL idle_retire got %h want 22", busy_mask); end
   endtask

   task automatic test_back_to_back();
      // Retire R1 and R5, then stream ADD, AND-imm, NOT with no hazards.
      wb_valid = 1'b1; wb_dr = 3'd1; cyc();
      wb_dr = 3'd5; cyc();
      wb_valid = 1'b0; #1;
      n_cmp++; if (busy_mask !== 8'h00) begin n_bad++; $display("FAIL b2b_pre got %h want 00", busy_mask); end
      in_valid = 1'b1; in_ir = 16'h1283; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy0 got %b want 1", in_ready); end
      cyc();
      in_ir = 16'h54E1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy1 got %b want 1", in_ready); end
      cyc();
      n_cmp++; if ({out_dr, out_sr1, out_sr2} !== {3'd2, 3'd3, 3'd0}) begin
         n_bad++; $display("FAIL and_imm got dr=%0d sr1=%0d sr2=%0d want 2 3 0", out_dr, out_sr1, out_sr2);
      end
      in_ir = 16'h9DFF; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy2 got %b want 1", in_ready); end
      cyc();
      in_valid = 1'b0; #1;
      n_cmp++; if ({out_dr, out_sr1, out_sr2} !== {3'd6, 3'd7, 3'd0}) begin
         n_bad++; $display("FAIL not_regs got dr=%0d sr1=%0d sr2=%0d want 6 7 0", out_dr, out_sr1, out_sr2);
      end
      n_cmp++; if (busy_mask !== 8'h46) begin n_bad++; $display("FAIL b2b_busy got %h want 46", busy_mask); end
   endtask

   task automatic test_illegal_reset();
      in_valid = 1'b1; in_ir = 16'hD000; in_npc = 16'h3007; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready got %b want 1", in_ready); end
      cyc();
      in_valid = 1'b0; out_ready = 1'b0; #1;
      n_cmp++; if ({out_valid, out_illegal, out_wb_en} !== 3'b110) begin
         n_bad++; $display("FAIL ill_flags got v=%b ill=%b wb_en=%b want 1 1 0", out_valid, out_illegal, out_wb_en);
      end
      n_cmp++; if (busy_mask !== 8'h46) begin n_bad++; $display("FAIL ill_busy got %h want 46", busy_mask); end
      rst = 1'b1;
      cyc();
      rst = 1'b0; #1;
      n_cmp++; if ({out_valid, busy_mask, out_ir} !== 25'd0) begin
         n_bad++; $display("FAIL midrst got v=%b busy=%h ir=%h want 0 00 0000", out_valid, busy_mask, out_ir);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_raw_bypass();
      test_br_cc();
      test_backpressure();
      test_wb_collision();
      test_back_to_back();
      test_illegal_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
